alu_muldiv: RTL and testbench
=============================

# alu_muldiv

Parametrised execute-stage ALU: single-cycle RV base integer and branch-compare operations plus an iterative M-extension multiply/divide unit, in a registered pipeline stage between decode and memory. Supersedes the fixed-width, always-accepting ALU with a valid/ready handshake, multi-cycle operations, flush support and a generic side-band bundle for downstream pipeline fields (mem enable, load flag, mem para, store value, PC, branch offset).

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64 only.
- SIDE_W, 256, width of the opaque side-band bundle carried with each op.

Ports:
- CLK  in  1  clock; single clock domain, all logic on rising edge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  squash in-flight op and output register.
- valid_i  in  1  op presented.
- ready_o  out  1  stage can accept; op transfers when valid_i && ready_o.
- op1, op2  in  XLEN  operands (op2 already muxed with immediate).
- funct3  in  3  RV funct3.
- funct7  in  7  RV funct7.
- imm  in  1  I-type; funct7 ignored except for shifts.
- word_inst  in  1  *W op (XLEN=64 only; ignored at XLEN=32).
- branch_flag_i  in  1  branch compare op.
- take_branch  in  1  kill writeback of this op.
- write_back_i  in  1  op writes rd.
- rd_i  in  5  destination register.
- side_i  in  SIDE_W  pass-through bundle.
- valid_o  out  1  result register valid (one-cycle pulse per op).
- res  out  XLEN  result; branch ops give {0…,taken}.
- alu_write_back_en  out  1  writeback enable.
- rd_o  out  5  destination register.
- branch_flag_o  out  1  copy of branch_flag_i.
- side_o  out  SIDE_W  copy of side_i.
- illegal_o  out  1  M op received with macro off.

## Operation
- Base ops: ADD/SUB (SUB only when !imm && funct7=0100000), SLL, SLT, SLTU, XOR, SRL/SRA (funct7=0100000), OR, AND; shift amount op2[5:0] at XLEN=64, op2[4:0] for word ops and XLEN=32. Word ops sign-extend bit 31.
- Branch ops (branch_flag_i): BEQ, BNE, BLT, BGE, BLTU, BGEU; funct3 010/011 give res=0.
- M ops: !imm && !branch_flag_i && funct7=0000001; funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; word forms MULW/DIVW/DIVUW/REMW/REMUW.
- FSM: IDLE → MUL or DIV on accepted M op → DONE → IDLE. IDLE executes base/branch ops directly into the output register.
- MUL: radix-2 shift-add on magnitudes, 2·XLEN-bit accumulator, sign fix-up in DONE. DIV: restoring, one quotient bit per cycle on magnitudes, sign fix-up in DONE.
- Divide by zero: quotient all-ones, remainder = dividend. Signed overflow (MIN / −1): quotient MIN, remainder 0. Both handled by the iterative path at normal latency, no early exit.
- take_branch=1 at accept: alu_write_back_en=0, rd_o=0, side_o still passed; res still computed.
- flush: FSM → IDLE, valid_o=0, alu_write_back_en=0 next cycle; an op presented in the same cycle is dropped (flush wins).

## Timing
- Reset values: valid_o 0, res 0, alu_write_back_en 0, rd_o 0, branch_flag_o 0, side_o 0, illegal_o 0, ready_o 1, FSM IDLE.
- Base/branch ops: accepted cycle N, valid_o and result in cycle N+1; back-to-back acceptance, ready_o stays 1.
- M ops: ready_o drops the cycle after acceptance; iteration count N_IT = 32 for word ops or XLEN=32, else 64; valid_o in cycle N+N_IT+2 (N_IT iterations + DONE); ready_o returns 1 in the same cycle as valid_o.
- Output register holds its value when no op completes; valid_o deasserts after one cycle, no downstream back-pressure.
- RST mid-operation aborts identically to flush and restores all reset values.

## Configuration
- ALU_MULDIV_EN defined: M ops execute as above.
- Undefined: no MUL/DIV datapath or FSM states; M op completes in 1 cycle with res=0, alu_write_back_en=0, illegal_o=1 for that cycle; ready_o constant 1.

## Test plan
- XLEN=64: op1=5, op2=7, funct3=000, funct7=0100000, !imm → res=0xFFFFFFFFFFFFFFFE, valid_o at N+1; SUBW with op1=0x80000000, op2=1 → res=0x000000007FFFFFFF.
- MULHU op1=op2=0xFFFFFFFFFFFFFFFF → res=0xFFFFFFFFFFFFFFFE at N+66; ready_o low N+1..N+65.
- DIV op1=0x8000000000000000, op2=−1 → res=0x8000000000000000; REM → 0; DIVU x/0 → all-ones; REMW 7/0 → 7.
- BLT op1=−1, op2=1 with take_branch=1 → res=1, alu_write_back_en=0, rd_o=0, side_o=side_i.
- DIV accepted, flush asserted 10 cycles later together with valid_i ADD → no valid_o for either; next ADD 2+3 returns 5 at N+1.
- Macro off: MUL 3×4 → res=0, illegal_o=1, alu_write_back_en=0 at N+1; following XOR unaffected.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with a registered output stage and an iterative multiply/divide unit.
// Define ALU_MULDIV_EN to build the M-extension datapath; otherwise M ops complete flagged illegal.
module alu_muldiv #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned SIDE_W = 256
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [XLEN-1:0]   op1,
   input  logic [XLEN-1:0]   op2,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic              imm,
   input  logic              word_inst,
   input  logic              branch_flag_i,
   input  logic              take_branch,
   input  logic              write_back_i,
   input  logic [4:0]        rd_i,
   input  logic [SIDE_W-1:0] side_i,
   output logic              valid_o,
   output logic [XLEN-1:0]   res,
   output logic              alu_write_back_en,
   output logic [4:0]        rd_o,
   output logic              branch_flag_o,
   output logic [SIDE_W-1:0] side_o,
   output logic              illegal_o
);

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   logic            weff, is_m, br_t;
   logic [5:0]      shamt;
   logic [XLEN-1:0] sh_src, alu_r, base_res;

   assign weff  = (XLEN == 64) && word_inst;
   assign shamt = (XLEN == 64 && !word_inst) ? op2[5:0] : {1'b0, op2[4:0]};
   assign is_m  = !imm && !branch_flag_i && (funct7 == 7'b0000001);

   always_comb begin
      sh_src = op1;
      if (weff) sh_src = funct7[5] ? sext32(op1[31:0]) : XLEN'(op1[31:0]);
      alu_r = '0;
      unique case (funct3)
         3'b000: alu_r = (!imm && funct7 == 7'b0100000) ? op1 - op2 : op1 + op2;
         3'b001: alu_r = op1 << shamt;
         3'b010: alu_r = XLEN'($signed(op1) < $signed(op2));
         3'b011: alu_r = XLEN'(op1 < op2);
         3'b100: alu_r = op1 ^ op2;
         3'b101: alu_r = funct7[5] ? XLEN'($signed(sh_src) >>> shamt) : sh_src >> shamt;
         3'b110: alu_r = op1 | op2;
         3'b111: alu_r = op1 & op2;
      endcase
      if (weff) alu_r = sext32(alu_r[31:0]);
   end

   always_comb begin
      br_t = 1'b0;
      case (funct3)
         3'b000:  br_t = (op1 == op2);
         3'b001:  br_t = (op1 != op2);
         3'b100:  br_t = ($signed(op1) <  $signed(op2));
         3'b101:  br_t = ($signed(op1) >= $signed(op2));
         3'b110:  br_t = (op1 <  op2);
         3'b111:  br_t = (op1 >= op2);
         default: br_t = 1'b0;
      endcase
      base_res = branch_flag_i ? XLEN'(br_t) : alu_r;
   end

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e            state_q;
   logic [6:0]        cnt_q;
   logic              short_q, word_q, div_q, sa_q, sb_q, dz_q;
   logic [2:0]        f3_q;
   logic [2*XLEN-1:0] acc_q, mcand_q, prod;
   logic [XLEN-1:0]   x_q, y_q, rem_q, quo, rem_s, m_res;
   logic [XLEN-1:0]   ext_a, ext_b, mag_a, mag_b;
   logic              sgn_a, sgn_b, neg_a, neg_b;
   logic [XLEN:0]     trial, diff;
   logic              pend_wb_q;
   logic [4:0]        pend_rd_q;
   logic [SIDE_W-1:0] pend_side_q;

   assign ready_o = (state_q == StIdle);

   // Both units iterate on operand magnitudes; signs are reapplied in StDone.
   always_comb begin
      sgn_a = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
      sgn_b = funct3[2] ? !funct3[0] : !funct3[1];
      ext_a = op1;
      ext_b = op2;
      if (weff) begin
         ext_a = sgn_a ? sext32(op1[31:0]) : XLEN'(op1[31:0]);
         ext_b = sgn_b ? sext32(op2[31:0]) : XLEN'(op2[31:0]);
      end
      neg_a = sgn_a && ext_a[XLEN-1];
      neg_b = sgn_b && ext_b[XLEN-1];
      mag_a = neg_a ? -ext_a : ext_a;
      mag_b = neg_b ? -ext_b : ext_b;
   end

   always_comb begin
      trial = {rem_q, x_q[XLEN-1]};
      diff  = trial - {1'b0, y_q};
      prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo   = dz_q ? '1 : ((sa_q ^ sb_q) ? -x_q : x_q);
      rem_s = sa_q ? -rem_q : rem_q;
      if (div_q)                   m_res = f3_q[1] ? rem_s : quo;
      else if (f3_q[1:0] == 2'b00) m_res = prod[XLEN-1:0];
      else                         m_res = prod[2*XLEN-1:XLEN];
      if (word_q) m_res = sext32(m_res[31:0]);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q           <= StIdle;
         valid_o           <= 1'b0;
         res               <= '0;
         alu_write_back_en <= 1'b0;
         rd_o              <= '0;
         branch_flag_o     <= 1'b0;
         side_o            <= '0;
         illegal_o         <= 1'b0;
      end else if (flush) begin
         state_q           <= StIdle;
         valid_o           <= 1'b0;
         alu_write_back_en <= 1'b0;
         illegal_o         <= 1'b0;
      end else begin
         valid_o   <= 1'b0;
         illegal_o <= 1'b0;
         unique case (state_q)
            StIdle: if (valid_i) begin
               if (is_m) begin
                  state_q     <= funct3[2] ? StDiv : StMul;
                  cnt_q       <= '0;
                  short_q     <= weff || (XLEN == 32);
                  word_q      <= weff;
                  div_q       <= funct3[2];
                  f3_q        <= funct3;
                  sa_q        <= neg_a;
                  sb_q        <= neg_b;
                  dz_q        <= (ext_b == '0);
                  acc_q       <= '0;
                  mcand_q     <= {{XLEN{1'b0}}, mag_a};
                  // Word divides start with the 32-bit dividend left-aligned.
                  x_q         <= funct3[2] ? (weff ? mag_a << 32 : mag_a) : mag_b;
                  y_q         <= mag_b;
                  rem_q       <= '0;
                  pend_wb_q   <= write_back_i && !take_branch;
                  pend_rd_q   <= take_branch ? '0 : rd_i;
                  pend_side_q <= side_i;
               end else begin
                  valid_o           <= 1'b1;
                  res               <= base_res;
                  alu_write_back_en <= write_back_i && !take_branch;
                  rd_o              <= take_branch ? '0 : rd_i;
                  branch_flag_o     <= branch_flag_i;
                  side_o            <= side_i;
               end
            end
            StMul: begin
               acc_q   <= acc_q + (x_q[0] ? mcand_q : '0);
               mcand_q <= mcand_q << 1;
               x_q     <= x_q >> 1;
               cnt_q   <= cnt_q + 7'd1;
               if (cnt_q == (short_q ? 7'd31 : 7'd63)) state_q <= StDone;
            end
            StDiv: begin
               rem_q <= diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
               x_q   <= {x_q[XLEN-2:0], !diff[XLEN]};
               cnt_q <= cnt_q + 7'd1;
               if (cnt_q == (short_q ? 7'd31 : 7'd63)) state_q <= StDone;
            end
            StDone: begin
               state_q           <= StIdle;
               valid_o           <= 1'b1;
               res               <= m_res;
               alu_write_back_en <= pend_wb_q;
               rd_o              <= pend_rd_q;
               branch_flag_o     <= 1'b0;
               side_o            <= pend_side_q;
            end
         endcase
      end
   end
`else
   assign ready_o = 1'b1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_o           <= 1'b0;
         res               <= '0;
         alu_write_back_en <= 1'b0;
         rd_o              <= '0;
         branch_flag_o     <= 1'b0;
         side_o            <= '0;
         illegal_o         <= 1'b0;
      end else if (flush) begin
         valid_o           <= 1'b0;
         alu_write_back_en <= 1'b0;
         illegal_o         <= 1'b0;
      end else begin
         valid_o   <= 1'b0;
         illegal_o <= 1'b0;
         if (valid_i) begin
            valid_o           <= 1'b1;
            res               <= is_m ? '0 : base_res;
            alu_write_back_en <= write_back_i && !take_branch && !is_m;
            rd_o              <= take_branch ? '0 : rd_i;
            branch_flag_o     <= branch_flag_i;
            side_o            <= side_i;
            illegal_o         <= is_m;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at XLEN=64; M-op checks follow ALU_MULDIV_EN.
module tb_alu_muldiv;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned SIDE_W = 256;

   logic              CLK;
   logic              RST, flush, valid_i, ready_o;
   logic [XLEN-1:0]   op1, op2, res;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic              imm, word_inst, branch_flag_i, take_branch, write_back_i;
   logic [4:0]        rd_i, rd_o;
   logic [SIDE_W-1:0] side_i, side_o;
   logic              valid_o, alu_write_back_en, branch_flag_o, illegal_o;

   int errors = 0;
   int checks = 0;

   alu_muldiv #(.XLEN(XLEN), .SIDE_W(SIDE_W)) dut (
      .CLK(CLK), .RST(RST), .flush(flush), .valid_i(valid_i), .ready_o(ready_o),
      .op1(op1), .op2(op2), .funct3(funct3), .funct7(funct7), .imm(imm),
      .word_inst(word_inst), .branch_flag_i(branch_flag_i), .take_branch(take_branch),
      .write_back_i(write_back_i), .rd_i(rd_i), .side_i(side_i), .valid_o(valid_o),
      .res(res), .alu_write_back_en(alu_write_back_en), .rd_o(rd_o),
      .branch_flag_o(branch_flag_o), .side_o(side_o), .illegal_o(illegal_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL timeout: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                        input logic [6:0] f7, input logic im, input logic wd, input logic br,
                        input logic tkb, input logic [4:0] rd);
      op1 = a; op2 = b; funct3 = f3; funct7 = f7; imm = im; word_inst = wd;
      branch_flag_i = br; take_branch = tkb; write_back_i = 1'b1; rd_i = rd;
      side_i = {4{a ^ b}};
      valid_i = 1'b1;
   endtask

   task automatic idle();
      valid_i = 1'b0;
      flush   = 1'b0;
   endtask

   // Waits from cycle N+1 for valid_o; lat is the cycle offset from acceptance.
   task automatic wait_valid(input int limit, output int lat, output bit rdy_low);
      lat = 1;
      rdy_low = 1'b1;
      while (!valid_o && lat < limit) begin
         if (ready_o) rdy_low = 1'b0;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; flush = 1'b0; valid_i = 1'b0; op1 = '0; op2 = '0; funct3 = '0; funct7 = '0;
      imm = 1'b0; word_inst = 1'b0; branch_flag_i = 1'b0; take_branch = 1'b0;
      write_back_i = 1'b0; rd_i = '0; side_i = '0;
      tick(); tick();
      RST = 1'b0;
      checks++; if (valid_o !== 1'b0) $display("FAIL rst_valid: got %b required 0", valid_o);
      else checks += 0;
      if (valid_o !== 1'b0) errors++;
      checks++; if (res !== 64'd0) begin errors++; $display("FAIL rst_res: got %h required 0", res); end
      checks++; if (alu_write_back_en !== 1'b0) begin
         errors++; $display("FAIL rst_wbe: got %b required 0", alu_write_back_en); end
      checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL rst_rd: got %0d required 0", rd_o); end
      checks++; if (branch_flag_o !== 1'b0) begin
         errors++; $display("FAIL rst_brf: got %b required 0", branch_flag_o); end
      checks++; if (side_o !== '0) begin errors++; $display("FAIL rst_side: got %h required 0", side_o); end
      checks++; if (illegal_o !== 1'b0) begin
         errors++; $display("FAIL rst_illegal: got %b required 0", illegal_o); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", ready_o); end
   endtask

   task automatic test_sub();
      drive(64'd5, 64'd7, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
      tick(); idle();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b required 1", valid_o); end
      checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         errors++; $display("FAIL sub_res: got %h required fffffffffffffffe", res); end
      checks++; if (alu_write_back_en !== 1'b1) begin
         errors++; $display("FAIL sub_wbe: got %b required 1", alu_write_back_en); end
      checks++; if (rd_o !== 5'd3) begin errors++; $display("FAIL sub_rd: got %0d required 3", rd_o); end
      drive(64'h8000_0000, 64'd1, 3'b000, 7'b0100000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4);
      tick(); idle();
      checks++; if (res !== 64'h0000_0000_7FFF_FFFF) begin
         errors++; $display("FAIL subw_res: got %h required 000000007fffffff", res); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  f3  [12] = '{3'b001, 3'b101, 3'b101, 3'b101, 3'b001, 3'b010,
                                3'b011, 3'b000, 3'b100, 3'b110, 3'b111, 3'b000};
      logic [6:0]  f7  [12] = '{7'h00, 7'h20, 7'h00, 7'h20, 7'h00, 7'h00,
                                7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
      logic        im  [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        wd  [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [63:0] a   [12] = '{64'd1, 64'h8000_0000_0000_0000, 64'h8000_0000, 64'h8000_0000,
                                64'h4000_0000, '1, '1, 64'd5, 64'hF0, 64'hF0, 64'hF0,
                                64'h7FFF_FFFF};
      logic [63:0] b   [12] = '{64'd65, 64'd4, 64'd4, 64'd4, 64'd33, 64'd1, 64'd1, 64'd7,
                                64'hFF, 64'h0F, 64'h3C, 64'd1};
      logic [63:0] exp [12] = '{64'd2, 64'hF800_0000_0000_0000, 64'h0800_0000,
                                64'hFFFF_FFFF_F800_0000, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'd0,
                                64'd12, 64'h0F, 64'hFF, 64'h30, 64'hFFFF_FFFF_8000_0000};
      for (int i = 0; i < 12; i++) begin
         drive(a[i], b[i], f3[i], f7[i], im[i], wd[i], 1'b0, 1'b0, 5'(i + 1));
         checks++; if (ready_o !== 1'b1) begin
            errors++; $display("FAIL b2b_ready[%0d]: got %b required 1", i, ready_o); end
         tick();
         checks++; if (valid_o !== 1'b1 || res !== exp[i]) begin
            errors++;
            $display("FAIL b2b_res[%0d]: got valid=%b res=%h required valid=1 res=%h",
                     i, valid_o, res, exp[i]);
         end
      end
      idle();
   endtask

   task automatic test_branch();
      logic [2:0]  f3  [6] = '{3'b000, 3'b001, 3'b101, 3'b110, 3'b010, 3'b111};
      logic [63:0] a   [6] = '{64'd3, 64'd3, '1, '1, 64'd5, '1};
      logic [63:0] b   [6] = '{64'd3, 64'd3, 64'd1, 64'd1, 64'd5, 64'd1};
      logic [63:0] exp [6] = '{64'd1, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1};
      logic [SIDE_W-1:0] side_exp;
      side_exp = {4{64'hFFFF_FFFF_FFFF_FFFE}};
      drive('1, 64'd1, 3'b100, 7'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7);
      tick(); idle();
      checks++; if (res !== 64'd1) begin errors++; $display("FAIL blt_res: got %h required 1", res); end
      checks++; if (alu_write_back_en !== 1'b0) begin
         errors++; $display("FAIL blt_wbe: got %b required 0", alu_write_back_en); end
      checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL blt_rd: got %0d required 0", rd_o); end
      checks++; if (side_o !== side_exp) begin
         errors++; $display("FAIL blt_side: got %h required %h", side_o, side_exp); end
      checks++; if (branch_flag_o !== 1'b1) begin
         errors++; $display("FAIL blt_brf: got %b required 1", branch_flag_o); end
      for (int i = 0; i < 6; i++) begin
         drive(a[i], b[i], f3[i], 7'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
         tick();
         checks++; if (res !== exp[i]) begin
            errors++; $display("FAIL br_res[%0d]: got %h required %h", i, res, exp[i]); end
      end
      idle();
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL hold_valid: got %b required 0", valid_o); end
      checks++; if (res !== 64'd1) begin errors++; $display("FAIL hold_res: got %h required 1", res); end
   endtask

`ifdef ALU_MULDIV_EN
   task automatic test_muldiv();
      logic [2:0]  f3  [12] = '{3'b011, 3'b000, 3'b010, 3'b001, 3'b100, 3'b110, 3'b101, 3'b110,
                                3'b100, 3'b110, 3'b000, 3'b101};
      logic        wd  [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b1};
      logic [63:0] a   [12] = '{'1, 64'hFFFF_FFFF_FFFF_FFFD, '1, '1, 64'h8000_0000_0000_0000,
                                64'h8000_0000_0000_0000, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF9,
                                64'hFFFF_FFFF_FFFF_FFF9, 64'd7, 64'h1_0000,
                                64'hFFFF_FFFF_FFFF_FFFE};
      logic [63:0] b   [12] = '{'1, 64'd5, '1, '1, '1, '1, 64'd0, 64'd2, 64'd2, 64'd0,
                                64'h8000, 64'd2};
      logic [63:0] exp [12] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF1, '1, 64'd0,
                                64'h8000_0000_0000_0000, 64'd0, '1, '1,
                                64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_8000_0000,
                                64'h7FFF_FFFF};
      int lat, want;
      bit rdy_low;
      for (int i = 0; i < 12; i++) begin
         want = wd[i] ? 34 : 66;
         drive(a[i], b[i], f3[i], 7'b0000001, 1'b0, wd[i], 1'b0, 1'b0, 5'd9);
         tick(); idle();
         checks++; if (ready_o !== 1'b0) begin
            errors++; $display("FAIL m_busy[%0d]: got ready=%b required 0", i, ready_o); end
         wait_valid(100, lat, rdy_low);
         checks++; if (lat !== want || valid_o !== 1'b1) begin
            errors++; $display("FAIL m_lat[%0d]: got %0d valid=%b required %0d", i, lat, valid_o, want); end
         checks++; if (res !== exp[i]) begin
            errors++; $display("FAIL m_res[%0d]: got %h required %h", i, res, exp[i]); end
         checks++; if (rdy_low !== 1'b1 || ready_o !== 1'b1) begin
            errors++; $display("FAIL m_ready[%0d]: got low=%b end=%b required 1/1", i, rdy_low, ready_o); end
         checks++; if (alu_write_back_en !== 1'b1 || rd_o !== 5'd9) begin
            errors++; $display("FAIL m_wb[%0d]: got %b/%0d required 1/9", i, alu_write_back_en, rd_o); end
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      drive(64'd3, 64'd4, 3'b000, 7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6);
      tick(); idle();
      repeat (5) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0 || res !== 64'd0) begin
         errors++; $display("FAIL rst_mid: got ready=%b valid=%b res=%h required 1/0/0",
                            ready_o, valid_o, res); end
      repeat (70) begin tick(); if (valid_o) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d pulses required 0", seen); end
   endtask
`else
   task automatic test_illegal();
      drive(64'd3, 64'd4, 3'b000, 7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6);
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL ill_ready: got %b required 1", ready_o); end
      tick(); idle();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ill_valid: got %b required 1", valid_o); end
      checks++; if (res !== 64'd0) begin errors++; $display("FAIL ill_res: got %h required 0", res); end
      checks++; if (illegal_o !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b required 1", illegal_o); end
      checks++; if (alu_write_back_en !== 1'b0) begin
         errors++; $display("FAIL ill_wbe: got %b required 0", alu_write_back_en); end
      drive(64'hF0, 64'hFF, 3'b100, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
      tick(); idle();
      checks++; if (res !== 64'h0F) begin errors++; $display("FAIL ill_xor_res: got %h required f", res); end
      checks++; if (illegal_o !== 1'b0 || alu_write_back_en !== 1'b1) begin
         errors++; $display("FAIL ill_xor_flags: got ill=%b wbe=%b required 0/1", illegal_o, alu_write_back_en); end
   endtask
`endif

   task automatic test_flush();
      int seen = 0;
`ifdef ALU_MULDIV_EN
      drive(64'd1000, 64'd7, 3'b100, 7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9);
      tick(); idle();
      repeat (9) tick();
`endif
      drive(64'd11, 64'd22, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
      flush = 1'b1;
      tick(); idle();
      checks++; if (valid_o !== 1'b0 || alu_write_back_en !== 1'b0) begin
         errors++; $display("FAIL flush_out: got valid=%b wbe=%b required 0/0", valid_o, alu_write_back_en); end
      checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b required 1", ready_o); end
      repeat (80) begin tick(); if (valid_o) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_quiet: got %0d pulses required 0", seen); end
      drive(64'd2, 64'd3, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
      tick(); idle();
      checks++; if (valid_o !== 1'b1 || res !== 64'd5) begin
         errors++; $display("FAIL flush_next: got valid=%b res=%h required 1/5", valid_o, res); end
   endtask

   initial begin
      test_reset();
      test_sub();
      test_back_to_back();
      test_branch();
`ifdef ALU_MULDIV_EN
      test_muldiv();
`else
      test_illegal();
`endif
      test_flush();
`ifdef ALU_MULDIV_EN
      test_reset_mid();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
